// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester RAM arbiter (instruction fetch port and data
// read/write port) sharing one RAM port.
//
// Handshake: a requester holds its request (iREN, or dREN/dWEN) high and
// watches its wait line. The wait line drops in the single cycle the RAM
// signals completion (ramready=1 while that requester owns the RAM). That
// cycle is also when iload/dload carry valid read data. After every
// completion the arbiter spends one cycle in IDLE before it grants again.
//
// Parameters:
//   STARVE_MAX  consecutive data grants allowed while a fetch waits
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   iREN, iaddr        instruction read request and address
//   iwait, iload       instruction stall and read data
//   dREN, dWEN         data read / write requests
//   daddr, dstore      data address and write value
//   dwait, dload       data stall and read data
//   ramREN, ramWEN     RAM strobes (registered)
//   ramaddr, ramstore  RAM address and write data (registered)
//   ramload, ramready  RAM read data and completion pulse
//   grant              current owner / FSM state: 00 idle, 01 instr, 10 data
//   starve_cnt         debug view of the starvation counter
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          iREN,
  input  logic [31:0]   iaddr,
  output logic          iwait,
  output logic [31:0]   iload,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [31:0]   daddr,
  input  logic [31:0]   dstore,
  output logic          dwait,
  output logic [31:0]   dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [31:0]   ramaddr,
  output logic [31:0]   ramstore,
  input  logic [31:0]   ramload,
  input  logic          ramready,
  output logic [1:0]    grant,
  output logic [SW-1:0] starve_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISERV = 2'b01,
    DSERV = 2'b10
  } state_t;

  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t      state;
  state_t      state_next;
  logic        d_req;
  logic        grant_i;
  logic        grant_d;
  logic        done;
  logic        ren_q;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic [SW-1:0] cnt_q;

  assign d_req   = dREN | dWEN;
  assign grant_i = (state == IDLE) && (state_next == ISERV);
  assign grant_d = (state == IDLE) && (state_next == DSERV);
  // Completion only counts while someone owns the RAM; a pulse in IDLE is stray.
  assign done    = (state != IDLE) && ramready;

  // Data normally wins; the fetch only overtakes once it has been passed over
  // STARVE_MAX times in a row.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_req && !(iREN && (cnt_q == STARVE_LIM))) state_next = DSERV;
        else if (iREN)                                 state_next = ISERV;
        else                                           state_next = IDLE;
      end
      ISERV, DSERV: begin
        if (ramready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The access parameters are latched at the grant edge and cleared at
  // completion, so the RAM side sees zeros whenever the arbiter is idle and
  // requester inputs moving mid-access have no effect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt_q   <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state <= state_next;
      if (grant_d) begin
        addr_q  <= daddr;
        store_q <= dstore;
        wen_q   <= dWEN;     // a simultaneous read+write is treated as a write
        ren_q   <= ~dWEN;
        if (!iREN)                    cnt_q <= '0;
        else if (cnt_q != STARVE_LIM) cnt_q <= cnt_q + 1'b1;
      end else if (grant_i) begin
        addr_q  <= iaddr;
        store_q <= '0;
        wen_q   <= 1'b0;
        ren_q   <= 1'b1;
        cnt_q   <= '0;
      end else if (done) begin
        addr_q  <= '0;
        store_q <= '0;
        wen_q   <= 1'b0;
        ren_q   <= 1'b0;
      end
    end
  end

  assign ramREN     = ren_q;
  assign ramWEN     = wen_q;
  assign ramaddr    = addr_q;
  assign ramstore   = store_q;
  assign grant      = state;
  assign starve_cnt = cnt_q;

  assign iwait = iREN  & ~((state == ISERV) & ramready);
  assign dwait = d_req & ~((state == DSERV) & ramready);
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, is the number of consecutive data grants allowed while an instruction request waits.
REQ-002 CLK  in  1  rising-edge clock; single clock domain.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 iREN  in  1  instruction fetch request (read only).
REQ-005 iaddr  in  32  instruction address.
REQ-006 iwait  out  1  high while the instruction request is pending and not completing.
REQ-007 iload  out  32  instruction read data, valid in the iREN completion cycle.
REQ-008 dREN  in  1  data read request.
REQ-009 dWEN  in  1  data write request.
REQ-010 daddr  in  32  data address.
REQ-011 dstore  in  32  data write value.
REQ-012 dwait  out  1  high while the data request is pending and not completing.
REQ-013 dload  out  32  data read value, valid in the dREN completion cycle.
REQ-014 ramREN  out  1  RAM read strobe.
REQ-015 ramWEN  out  1  RAM write strobe.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramready  in  1  one-cycle pulse marking RAM access completion.
REQ-020 grant  out  2  current owner: 00 none, 01 instruction, 10 data.

Function
REQ-021 FSM states are IDLE, ISERV and DSERV; grant encodes the state (IDLE=00, ISERV=01, DSERV=10).
REQ-022 In IDLE, a data request (dREN|dWEN) moves the FSM to DSERV next cycle, unless iREN is high and starve_cnt==STARVE_MAX, in which case it moves to ISERV.
REQ-023 In IDLE with iREN only, the FSM moves to ISERV next cycle; with no request it stays in IDLE.
REQ-024 At the grant edge, the block registers the winning address, write data and direction; ramaddr, ramstore, ramREN and ramWEN are driven only from these registers.
REQ-025 Input changes during ISERV or DSERV are ignored.
REQ-026 In ISERV, ramREN=1 and ramWEN=0; in DSERV, exactly one of ramWEN or ramREN is high.
REQ-027 When dREN and dWEN are both high at grant, the write takes precedence: ramWEN=1 and ramREN=0.
REQ-028 In IDLE, ramREN=0, ramWEN=0, ramaddr=0 and ramstore=0.
REQ-029 A transaction is held until ramready=1; the FSM returns to IDLE the following cycle, never directly to another serve state.
REQ-030 The mandatory IDLE cycle prevents re-sampling a request that has just completed.
REQ-031 iwait = iREN & ~(state==ISERV & ramready), combinational.
REQ-032 dwait = (dREN|dWEN) & ~(state==DSERV & ramready), combinational.
REQ-033 iload = ramload and dload = ramload, passed through combinationally; they are meaningful only in the owner's completion cycle.
REQ-034 A request deasserted mid-transaction does not abort the access; the access completes and its result is discarded.
REQ-035 starve_cnt (width clog2(STARVE_MAX+1)) increments, saturating at STARVE_MAX, on a DSERV grant made while iREN=1.
REQ-036 starve_cnt clears to 0 on an ISERV grant, or on a DSERV grant made with iREN=0.
REQ-037 Minimum latency is 3 cycles from request edge to completion cycle (grant, RAM access, ramready=1 in the next cycle); each additional RAM wait cycle adds one cycle.
REQ-038 A ramready pulse that arrives in IDLE is ignored.

Reset
REQ-039 When RST is high at a CLK edge: state=IDLE, starve_cnt=0, captured registers=0; resulting outputs are ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, grant=00.
REQ-040 Reset asserted mid-transaction abandons the access with no completion reported; iwait and dwait continue to follow their request inputs.

Verification
REQ-041 Single fetch: iREN=1, iaddr=0x100, ramready delayed 2 cycles, ramload=0x8C010004 -> ramREN=1 with ramaddr=0x100 from cycle 1; iwait=0 and iload=0x8C010004 in the ramready cycle; grant=00 next cycle.
REQ-042 Simultaneous requests: iREN=1 and dREN=1 with daddr=0x200 from IDLE -> DSERV is served first; ISERV is granted after one IDLE cycle.
REQ-043 Starvation: dWEN held continuously, iREN held, STARVE_MAX=4 -> four DSERV grants, then an ISERV grant; starve_cnt reads 0 after it.
REQ-044 Write precedence and capture: dREN=dWEN=1, daddr=0x40, dstore=0xDEADBEEF, daddr changed to 0x80 mid-transaction -> ramWEN=1, ramREN=0, ramaddr held at 0x40 and ramstore at 0xDEADBEEF until ramready.
REQ-045 Reset mid-transaction: RST=1 while in DSERV -> state IDLE and all RAM outputs 0 the next cycle; a later ramready pulse has no effect.
REQ-046 Stray ready: ramready=1 in IDLE with no requests -> no state change, iwait=0, dwait=0.
